match_sequencer: RTL and testbench

Central game-flow controller for the ping-pong design. It sequences the match through idle, serve countdown, live play and game over, and owns both player scores. It gates the ball datapath with a hold-at-centre / enable pair and chooses the serve direction. Its outputs drive the renderer (game_state), the seven-segment block (scores) and the ball logic (ball_reset, ball_enable, serve_dir).

---
 rtl/pong_pkg.sv | 18 +
 rtl/match_sequencer_btn_edge.sv | 30 +++
 rtl/match_sequencer.sv | 176 +++++++++++++++++
 tb/tb_match_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the ping-pong design: match states, serve directions
// and default match timing.
package pong_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    // Serve direction and winner share this encoding: 0 = player 1, 1 = player 2.
    localparam logic DIR_P1 = 1'b0;
    localparam logic DIR_P2 = 1'b1;

    localparam int unsigned DEF_WIN_SCORE      = 9;
    localparam int unsigned DEF_SERVE_DELAY_MS = 1000;
    localparam int unsigned DEF_CNT_W          = 16;

endpackage

// File: rtl/match_sequencer_btn_edge.sv
// Push-button conditioner: 2-flop synchronizer followed by a rising-edge
// detector producing a single-cycle pulse per press.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Reset treats the button as already pressed, so a button held through
    // reset gives no pulse until it is released and pressed again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/match_sequencer.sv
// Game-flow controller: sequences idle/serve/play/over, owns both scores and
// gates the ball datapath.
module match_sequencer
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE      = DEF_WIN_SCORE,
    parameter int unsigned SERVE_DELAY_MS = DEF_SERVE_DELAY_MS,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1ms,
    input  logic       start_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [1:0] game_state,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       ball_reset,
    output logic       ball_enable,
    output logic       serve_dir,
    output logic       point_pulse,
    output logic       winner
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY_MS - 1);
    localparam logic [3:0]       WIN_VAL  = 4'(WIN_SCORE);

    logic             w_start_rise;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_p1;
    logic [3:0]       r_p2;
    logic             r_dir;
    logic             r_win;
    logic             r_point;
    logic             r_ball_reset;
    logic             r_ball_enable;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_p1_nxt;
    logic [3:0]       w_p2_nxt;
    logic             w_dir_nxt;
    logic             w_win_nxt;
    logic             w_point_nxt;
    logic [3:0]       w_p1_inc;
    logic [3:0]       w_p2_inc;

    btn_edge u_start_edge (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (start_btn),
        .o_rise (w_start_rise)
    );

    assign w_p1_inc = r_p1 + 4'd1;
    assign w_p2_inc = r_p2 + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_p1_nxt    = r_p1;
        w_p2_nxt    = r_p2;
        w_dir_nxt   = r_dir;
        w_win_nxt   = r_win;
        w_point_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_p1_nxt    = '0;
                    w_p2_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_dir_nxt   = DIR_P2;
                    w_state_nxt = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (tick_1ms) begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_PLAY;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end

            ST_PLAY: begin
                // A double miss is a let: re-serve with scores and direction kept.
                case ({miss_left, miss_right})
                    2'b10: begin
                        w_p2_nxt    = w_p2_inc;
                        w_dir_nxt   = DIR_P1;
                        w_point_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        if (w_p2_inc == WIN_VAL) begin
                            w_win_nxt   = DIR_P2;
                            w_state_nxt = ST_OVER;
                        end else begin
                            w_state_nxt = ST_SERVE;
                        end
                    end
                    2'b01: begin
                        w_p1_nxt    = w_p1_inc;
                        w_dir_nxt   = DIR_P2;
                        w_point_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        if (w_p1_inc == WIN_VAL) begin
                            w_win_nxt   = DIR_P1;
                            w_state_nxt = ST_OVER;
                        end else begin
                            w_state_nxt = ST_SERVE;
                        end
                    end
                    2'b11: begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_SERVE;
                    end
                    default: ;
                endcase
            end

            ST_OVER: begin
                if (w_start_rise) begin
                    w_p1_nxt    = '0;
                    w_p2_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_dir_nxt   = ~r_win;
                    w_state_nxt = ST_SERVE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Ball gating is registered from the next state so it changes on the same
    // edge as game_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_p1          <= '0;
            r_p2          <= '0;
            r_dir         <= DIR_P2;
            r_win         <= DIR_P1;
            r_point       <= 1'b0;
            r_ball_reset  <= 1'b1;
            r_ball_enable <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_p1          <= w_p1_nxt;
            r_p2          <= w_p2_nxt;
            r_dir         <= w_dir_nxt;
            r_win         <= w_win_nxt;
            r_point       <= w_point_nxt;
            r_ball_reset  <= (w_state_nxt != ST_PLAY);
            r_ball_enable <= (w_state_nxt == ST_PLAY);
        end
    end

    assign game_state  = r_state;
    assign p1_score    = r_p1;
    assign p2_score    = r_p2;
    assign ball_reset  = r_ball_reset;
    assign ball_enable = r_ball_enable;
    assign serve_dir   = r_dir;
    assign point_pulse = r_point;
    assign winner      = r_win;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with WIN_SCORE=3, SERVE_DELAY_MS=4 and a
// tick every 10 clocks.
module tb_match_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1ms;
    logic       start_btn;
    logic       miss_left;
    logic       miss_right;
    logic [1:0] game_state;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       ball_reset;
    logic       ball_enable;
    logic       serve_dir;
    logic       point_pulse;
    logic       winner;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_div = 0;

    match_sequencer #(
        .WIN_SCORE      (3),
        .SERVE_DELAY_MS (4),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1ms    (tick_1ms),
        .start_btn   (start_btn),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .game_state  (game_state),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .ball_reset  (ball_reset),
        .ball_enable (ball_enable),
        .serve_dir   (serve_dir),
        .point_pulse (point_pulse),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    // Tick changes 2 time units after the rising edge, one clock in ten.
    initial begin
        tick_1ms = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tick_div = (tick_div == 9) ? 0 : tick_div + 1;
            tick_1ms = (tick_div == 9);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget, input string tag);
        int c = 0;
        while (game_state !== target && c < budget) begin
            step();
            c++;
        end
        check(tag, game_state, target);
    endtask

    task automatic miss(input logic l, input logic r);
        @(negedge clk);
        miss_left  = l;
        miss_right = r;
        step();
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic press();
        @(negedge clk);
        start_btn = 1'b1;
        step();
    endtask

    task automatic release_btn();
        @(negedge clk);
        start_btn = 1'b0;
        repeat (3) step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"},  game_state, 0);
        check({tag, "_p1"},     p1_score, 0);
        check({tag, "_p2"},     p2_score, 0);
        check({tag, "_dir"},    serve_dir, 1);
        check({tag, "_winner"}, winner, 0);
        check({tag, "_pp"},     point_pulse, 0);
    endtask

    initial begin
        int  ticks;
        bit  early_ok;
        logic t;

        reset = 1'b1; start_btn = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        repeat (3) step();
        check_reset_state("rst");
        check("rst_ball_reset", ball_reset, 1);
        check("rst_ball_enable", ball_enable, 0);
        @(negedge clk); reset = 1'b0;
        repeat (5) step();

        // Misses in IDLE are ignored
        miss(1'b1, 1'b1);
        check("idle_both_state", game_state, 0);
        miss(1'b1, 1'b0);
        check("idle_ml_p2", p2_score, 0);
        check("idle_ml_pp", point_pulse, 0);

        // Test 1: start latency and serve countdown
        @(negedge clk); start_btn = 1'b1;
        step(); check("start_lat1", game_state, 0);
        step(); check("start_lat2", game_state, 0);
        step(); check("start_lat3", game_state, 1);
        check("serve_dir_init", serve_dir, 1);
        ticks = 0; early_ok = 1'b1;
        for (int c = 0; c < 200 && ticks < 4; c++) begin
            @(negedge clk); t = tick_1ms;
            step();
            if (t) ticks++;
            if (ticks < 4 && game_state !== 2'd1) early_ok = 1'b0;
        end
        check("serve_held_until_4th", early_ok, 1);
        check("play_after_4th", game_state, 2);
        check("play_ball_enable", ball_enable, 1);
        check("play_ball_reset", ball_reset, 0);
        release_btn();
        check("held_btn_no_effect", game_state, 2);

        // Test 2: single points
        miss(1'b0, 1'b1);
        check("mr_p1", p1_score, 1);
        check("mr_pp", point_pulse, 1);
        check("mr_dir", serve_dir, 1);
        check("mr_state", game_state, 1);
        check("mr_ball_reset", ball_reset, 1);
        step();
        check("mr_pp_one_cycle", point_pulse, 0);
        wait_state(2'd2, 200, "serve2_to_play");
        miss(1'b1, 1'b0);
        check("ml_p2", p2_score, 1);
        check("ml_dir", serve_dir, 0);
        check("ml_p1_kept", p1_score, 1);

        // Test 3: simultaneous misses
        wait_state(2'd2, 200, "serve3_to_play");
        miss(1'b1, 1'b1);
        check("both_p1", p1_score, 1);
        check("both_p2", p2_score, 1);
        check("both_pp", point_pulse, 0);
        check("both_state", game_state, 1);
        check("both_dir", serve_dir, 0);
        miss(1'b1, 1'b1);
        check("serve_both_p2", p2_score, 1);
        check("serve_both_state", game_state, 1);

        // Test 4: player 2 reaches WIN_SCORE
        wait_state(2'd2, 200, "serve4_to_play");
        miss(1'b1, 1'b0);
        check("p2_two", p2_score, 2);
        wait_state(2'd2, 200, "serve5_to_play");
        miss(1'b1, 1'b0);
        check("p2_win_score", p2_score, 3);
        check("p2_win_state", game_state, 3);
        check("p2_win_winner", winner, 1);
        check("p2_win_pp", point_pulse, 1);
        for (int i = 0; i < 30; i++) miss(i[0], ~i[0]);
        check("over_frozen_state", game_state, 3);
        check("over_frozen_p1", p1_score, 1);
        check("over_frozen_p2", p2_score, 3);
        check("over_ball_reset", ball_reset, 1);
        press();
        wait_state(2'd1, 6, "restart_serve");
        check("restart_p1", p1_score, 0);
        check("restart_p2", p2_score, 0);
        check("restart_dir", serve_dir, 0);

        // Test 5a: reset mid-serve with counter at 2, button held through it
        ticks = 0;
        for (int c = 0; c < 100 && ticks < 2; c++) begin
            @(negedge clk); t = tick_1ms;
            step();
            if (t) ticks++;
        end
        check("pre_reset_serve", game_state, 1);
        @(negedge clk); reset = 1'b1;
        step();
        check_reset_state("rst_serve");
        @(negedge clk); reset = 1'b0;
        repeat (10) step();
        check("held_through_reset", game_state, 0);
        release_btn();
        check("released_idle", game_state, 0);
        press();
        wait_state(2'd1, 6, "repress_serve");

        // Player 1 wins, then restart serves toward player 2
        for (int k = 0; k < 3; k++) begin
            wait_state(2'd2, 200, "p1run_to_play");
            release_btn();
            miss(1'b0, 1'b1);
        end
        check("p1_win_score", p1_score, 3);
        check("p1_win_state", game_state, 3);
        check("p1_win_winner", winner, 0);
        press();
        wait_state(2'd1, 6, "restart2_serve");
        check("restart2_dir", serve_dir, 1);

        // Test 5b: reset while in OVER with winner = player 2
        for (int k = 0; k < 3; k++) begin
            wait_state(2'd2, 200, "p2run_to_play");
            release_btn();
            miss(1'b1, 1'b0);
        end
        check("p2_win2_winner", winner, 1);
        check("p2_win2_state", game_state, 3);
        @(negedge clk); reset = 1'b1;
        step();
        check_reset_state("rst_over");
        @(negedge clk); reset = 1'b0;
        repeat (5) step();
        check("after_rst_over_idle", game_state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
